// File: rtl/jk_excitation_driver_if.sv
// Target handshake channel for jk_excitation_driver: a valid/ready word carrying
// the desired next state of the JK bank.
interface jk_excitation_driver_if #(
  parameter int unsigned WIDTH = 8
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (
    output tgt_valid,
    output tgt_data,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_data,
    output tgt_ready
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives an external JK flip-flop bank to a requested word, checks the read-back
// and re-drives up to MAX_RETRY times before reporting an error.
module jk_excitation_driver #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TOGGLE_MODE = 0,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  jk_excitation_driver_if.slave tgt,
  input  logic [WIDTH-1:0]      jk_q,
  output logic [WIDTH-1:0]      jk_j,
  output logic [WIDTH-1:0]      jk_k,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            retry_cnt
);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

  localparam logic [3:0] MaxRetryCnt = 4'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_reg_q, tgt_reg_d;
  logic [3:0]       retry_cnt_q, retry_cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      tgt_reg_q   <= '0;
      retry_cnt_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_reg_q   <= tgt_reg_d;
      retry_cnt_q <= retry_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tgt_reg_d   = tgt_reg_q;
    retry_cnt_d = retry_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (tgt.tgt_valid) begin
          tgt_reg_d   = tgt.tgt_data;
          retry_cnt_d = '0;
          state_d     = StDrive;
        end
      end
      StDrive: state_d = StCheck;
      StCheck: begin
        if (jk_q == tgt_reg_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (retry_cnt_q < MaxRetryCnt) begin
          retry_cnt_d = retry_cnt_q + 4'd1;
          state_d     = StDrive;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Excitation is only presented in DRIVE; the async reset of state_q forces it
  // back to zero the moment reset rises.
  always_comb begin
    jk_j = '0;
    jk_k = '0;
    if (state_q == StDrive) begin
      if (TOGGLE_MODE != 0) begin
        jk_j = jk_q ^ tgt_reg_q;
        jk_k = jk_q ^ tgt_reg_q;
      end else begin
        jk_j = ~jk_q & tgt_reg_q;
        jk_k = jk_q & ~tgt_reg_q;
      end
    end
  end

  assign tgt.tgt_ready = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign err           = err_q;
  assign retry_cnt     = retry_cnt_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench: set/reset and toggle encoders side by side, each on an ideal JK bank
// with an optional stuck-at-0 mask.
module tb_jk_excitation_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic [7:0] data;
  logic [7:0] stuck;

  logic [7:0] bank_s, bank_t, j_s, k_s, j_t, k_t;
  logic       busy_s, done_s, err_s, busy_t, done_t, err_t;
  logic [3:0] retry_s, retry_t;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  jk_excitation_driver_if #(.WIDTH(8)) if_s ();
  jk_excitation_driver_if #(.WIDTH(8)) if_t ();

  assign if_s.tgt_valid = valid;
  assign if_s.tgt_data  = data;
  assign if_t.tgt_valid = valid;
  assign if_t.tgt_data  = data;

  jk_excitation_driver #(.WIDTH(8), .TOGGLE_MODE(0), .MAX_RETRY(2)) u_dut_s (
    .clk(clk), .reset(reset), .tgt(if_s.slave), .jk_q(bank_s), .jk_j(j_s), .jk_k(k_s),
    .busy(busy_s), .done(done_s), .err(err_s), .retry_cnt(retry_s)
  );

  jk_excitation_driver #(.WIDTH(8), .TOGGLE_MODE(1), .MAX_RETRY(2)) u_dut_t (
    .clk(clk), .reset(reset), .tgt(if_t.slave), .jk_q(bank_t), .jk_j(j_t), .jk_k(k_t),
    .busy(busy_t), .done(done_t), .err(err_t), .retry_cnt(retry_t)
  );

  function automatic logic [7:0] jk_next(input logic [7:0] q, input logic [7:0] j,
                                         input logic [7:0] k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      case ({j[i], k[i]})
        2'b00:   r[i] = q[i];
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = 1'b1;
        default: r[i] = ~q[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_s <= '0;
      bank_t <= '0;
    end else begin
      bank_s <= jk_next(bank_s, j_s, k_s) & ~stuck;
      bank_t <= jk_next(bank_t, j_t, k_t) & ~stuck;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [7:0] tgt;
    logic [7:0] stuck;
    logic [7:0] j_s, k_s, j_t, k_t;
    logic [7:0] bank;
    int         cycles;
    logic       done_e, err_e;
    logic [3:0] retry;
  } vec_t;

  vec_t vecs[6];
  int   n;

  task automatic wait_end();
    n = 0;
    while (!(done_s || err_s || done_t || err_t) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    // tgt, stuck, J/K set-reset, J/K toggle, final bank, cycles, done, err, retry
    vecs[0] = '{8'hA5, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5, 2, 1'b1, 1'b0, 4'd0};
    vecs[1] = '{8'h5A, 8'h00, 8'h5A, 8'hA5, 8'hFF, 8'hFF, 8'h5A, 2, 1'b1, 1'b0, 4'd0};
    vecs[2] = '{8'h3C, 8'h00, 8'h24, 8'h42, 8'h66, 8'h66, 8'h3C, 2, 1'b1, 1'b0, 4'd0};
    vecs[3] = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 2, 1'b1, 1'b0, 4'd0};
    vecs[4] = '{8'h01, 8'h01, 8'h01, 8'h3C, 8'h3D, 8'h3D, 8'h00, 6, 1'b0, 1'b1, 4'd2};
    vecs[5] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 2, 1'b1, 1'b0, 4'd0};

    // Reset, with a valid target offered that must not be taken.
    reset = 1'b1; valid = 1'b1; data = 8'hFF; stuck = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_s, 0);
    chk("rst_ready", if_s.tgt_ready, 1);
    chk("rst_jk", {j_s, k_s, j_t, k_t}, 0);
    chk("rst_done_err", {done_s, err_s}, 0);
    chk("rst_retry", retry_s, 0);
    valid = 1'b0;
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      stuck = vecs[i].stuck; valid = 1'b1; data = vecs[i].tgt;
      @(posedge clk); #1;
      valid = 1'b0;
      chk($sformatf("v%0d_busy", i), {busy_s, busy_t}, 2'b11);
      chk($sformatf("v%0d_j_s", i), j_s, vecs[i].j_s);
      chk($sformatf("v%0d_k_s", i), k_s, vecs[i].k_s);
      chk($sformatf("v%0d_j_t", i), j_t, vecs[i].j_t);
      chk($sformatf("v%0d_k_t", i), k_t, vecs[i].k_t);
      wait_end();
      chk($sformatf("v%0d_cycles", i), n, vecs[i].cycles);
      chk($sformatf("v%0d_done_err_s", i), {done_s, err_s}, {vecs[i].done_e, vecs[i].err_e});
      chk($sformatf("v%0d_done_err_t", i), {done_t, err_t}, {vecs[i].done_e, vecs[i].err_e});
      chk($sformatf("v%0d_retry", i), {retry_s, retry_t}, {vecs[i].retry, vecs[i].retry});
      chk($sformatf("v%0d_bank_s", i), bank_s, vecs[i].bank);
      chk($sformatf("v%0d_bank_t", i), bank_t, vecs[i].bank);
      chk($sformatf("v%0d_ready", i), {if_s.tgt_ready, if_t.tgt_ready}, 2'b11);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse_end", i), {done_s, err_s, done_t, err_t}, 0);
      chk($sformatf("v%0d_retry_hold", i), retry_s, vecs[i].retry);
    end

    // Back-to-back with valid held high; data changed while busy must be ignored.
    stuck = 8'h00; valid = 1'b1; data = 8'h11;
    @(posedge clk); #1;
    data = 8'h77;
    chk("b2b_busy0", busy_s, 1);
    @(posedge clk); #1;
    chk("b2b_no_early_done", done_s, 0);
    @(posedge clk); #1;
    chk("b2b_done_ready", {done_s, if_s.tgt_ready, done_t, if_t.tgt_ready}, 4'b1111);
    chk("b2b_bank0", {bank_s, bank_t}, 16'h1111);
    data = 8'h22;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("b2b_accept", {busy_s, done_s}, 2'b10);
    chk("b2b_jk_s", {j_s, k_s}, 16'h2211);
    chk("b2b_jk_t", {j_t, k_t}, 16'h3333);
    wait_end();
    chk("b2b_cycles", n, 2);
    chk("b2b_done2", {done_s, err_s, done_t, err_t}, 4'b1010);
    chk("b2b_bank1", {bank_s, bank_t}, 16'h2222);

    // Reset in the middle of DRIVE.
    @(posedge clk); #1;
    valid = 1'b1; data = 8'hF0;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("mid_jk_s", {j_s, k_s}, 16'hD002);
    chk("mid_jk_t", {j_t, k_t}, 16'hD2D2);
    #2 reset = 1'b1;
    valid = 1'b1; data = 8'h0F;
    #1;
    chk("mid_rst_jk", {j_s, k_s, j_t, k_t}, 0);
    chk("mid_rst_idle", {busy_s, if_s.tgt_ready, busy_t}, 3'b010);
    @(posedge clk); #1;
    chk("mid_rst_no_hs", {busy_s, busy_t}, 0);
    chk("mid_rst_no_pulse", {done_s, err_s, done_t, err_t}, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("post_rst_accept", {busy_s, busy_t}, 2'b11);
    chk("post_rst_jk_s", {j_s, k_s}, 16'h0F00);
    chk("post_rst_jk_t", {j_t, k_t}, 16'h0F0F);
    wait_end();
    chk("post_rst_cycles", n, 2);
    chk("post_rst_done", {done_s, err_s, done_t, err_t}, 4'b1010);
    chk("post_rst_bank", {bank_s, bank_t}, 16'h0F0F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
